// File: rtl/bcd_input_pkg.sv
// Shared types and helpers for the operator BCD entry port.
// The reverse double-dabble step is kept here so the converter stays a plain FSM.
package bcd_input_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int BIN_W      = 14;
  localparam int NIBBLES    = 4;
  localparam int CONV_ITERS = 14;
  localparam int SR_W       = 4 * NIBBLES + BIN_W;

  // One reverse double-dabble iteration: shift right, then pull every digit >= 8 back by 3.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] s;
    s = sr >> 1;
    for (int n = 0; n < NIBBLES; n++) begin
      if (s[BIN_W + 4*n + 3])
        s[BIN_W + 4*n +: 4] = s[BIN_W + 4*n +: 4] - 4'd3;
    end
    return s;
  endfunction

  function automatic logic has_bad_digit(input logic [4*NIBBLES-1:0] w);
    logic bad;
    bad = 1'b0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (w[4*n +: 4] > 4'd9)
        bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Load button conditioning: 2-FF synchronizer, stability counter, and a
// one-cycle pulse on each accepted 0->1 transition of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic load
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_s1;
  logic             btn_s2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      load   <= 1'b0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      load   <= 1'b0;
      // Any cycle where the input agrees with the accepted level restarts the count.
      if (btn_s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_TC) begin
        level <= btn_s2;
        cnt   <= '0;
        load  <= btn_s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_input_port.sv
// Operator entry front end: debounced load captures four BCD switch digits,
// converts them to binary over 14 clocks and offers the result via VALID/ACK.
//
//   state | meaning
//   IDLE  | waiting for a debounced load press
//   CONV  | one reverse double-dabble iteration per clock
//   HOLD  | result presented, VALID high until ACK
module bcd_input_port
  import bcd_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk100mhz,
  input  logic        RESET,
  input  logic [15:0] SW,
  input  logic        BTN,
  input  logic        ACK,
  output logic [15:0] DOUT,
  output logic        VALID,
  output logic        ERR,
  output logic        OVF8,
  output logic        BUSY
);

  logic            load;
  logic [15:0]     sw_s1;
  logic [15:0]     sw_s2;
  state_t          state;
  state_t          state_nx;
  logic [SR_W-1:0] sr;
  logic [SR_W-1:0] sr_nx;
  logic [SR_W-1:0] sr_step;
  logic [3:0]      iter;
  logic [3:0]      iter_nx;
  logic [15:0]     dout_nx;
  logic            err_nx;
  logic            ovf_nx;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk  (clk100mhz),
    .rst  (RESET),
    .btn  (BTN),
    .load (load)
  );

  always_ff @(posedge clk100mhz or posedge RESET) begin
    if (RESET) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      state <= IDLE;
      sr    <= '0;
      iter  <= '0;
      DOUT  <= '0;
      ERR   <= 1'b0;
      OVF8  <= 1'b0;
    end else begin
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
      state <= state_nx;
      sr    <= sr_nx;
      iter  <= iter_nx;
      DOUT  <= dout_nx;
      ERR   <= err_nx;
      OVF8  <= ovf_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    iter_nx  = iter;
    dout_nx  = DOUT;
    err_nx   = ERR;
    ovf_nx   = OVF8;
    sr_step  = dabble_step(sr);
    case (state)
      IDLE: begin
        if (load) begin
          sr_nx   = {sw_s2, {BIN_W{1'b0}}};
          iter_nx = '0;
          if (has_bad_digit(sw_s2)) begin
            err_nx   = 1'b1;
            dout_nx  = '0;
            ovf_nx   = 1'b0;
            state_nx = HOLD;
          end else begin
            state_nx = CONV;
          end
        end
      end
      CONV: begin
        sr_nx   = sr_step;
        iter_nx = iter + 4'd1;
        if (iter == 4'(CONV_ITERS - 1)) begin
          dout_nx  = {{(16-BIN_W){1'b0}}, sr_step[BIN_W-1:0]};
          ovf_nx   = (sr_step[BIN_W-1:0] > 14'd255);
          err_nx   = 1'b0;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (ACK)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign VALID = (state == HOLD);
  assign BUSY  = (state != IDLE);

endmodule

// File: tb/tb_bcd_input_port.sv
// Self-checking bench for bcd_input_port with a short debounce window.
module tb_bcd_input_port;

  logic        clk;
  logic        RESET;
  logic [15:0] SW;
  logic        BTN;
  logic        ACK;
  logic [15:0] DOUT;
  logic        VALID;
  logic        ERR;
  logic        OVF8;
  logic        BUSY;

  int passes = 0;
  int total  = 0;

  bcd_input_port #(.DEBOUNCE_CYCLES(4)) dut (
    .clk100mhz (clk),
    .RESET     (RESET),
    .SW        (SW),
    .BTN       (BTN),
    .ACK       (ACK),
    .DOUT      (DOUT),
    .VALID     (VALID),
    .ERR       (ERR),
    .OVF8      (OVF8),
    .BUSY      (BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [15:0] sw;
    logic [15:0] sw_mid;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Decimal interpretation of the switch word, straight from the digit rules.
  function automatic void model(input logic [15:0] sw, output logic [15:0] d,
                                output logic e, output logic o);
    int v;
    int dig;
    v = 0;
    e = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      dig = int'((sw >> (4*i)) & 16'hF);
      if (dig > 9) e = 1'b1;
      v = v * 10 + dig;
    end
    if (e) begin
      d = 16'd0;
      o = 1'b0;
    end else begin
      d = 16'(v);
      o = (v > 255);
    end
  endfunction

  // Press, convert, release; leaves the DUT in HOLD with the button debounced low.
  task automatic do_conv(input logic [15:0] sw, input logic [15:0] sw_mid, input string tag);
    logic [15:0] ed;
    logic        ee;
    logic        eo;
    int c, busy_c, valid_c, conv_cycles, bad;
    model(sw, ed, ee, eo);
    SW = sw;
    repeat (3) @(negedge clk);
    BTN = 1'b1;
    c = 0; busy_c = -1; valid_c = -1; conv_cycles = 0;
    while (valid_c < 0 && c < 100) begin
      @(negedge clk);
      c++;
      if (BUSY && busy_c < 0) begin
        busy_c = c;
        SW = sw_mid;
      end
      if (BUSY && !VALID) conv_cycles++;
      if (VALID) valid_c = c;
    end
    check({tag, " busy_start"}, busy_c, 7);
    check({tag, " valid_latency"}, valid_c, ee ? 7 : 21);
    check({tag, " conv_cycles"}, conv_cycles, ee ? 0 : 14);
    check({tag, " dout"}, int'(DOUT), int'(ed));
    check({tag, " err"}, int'(ERR), int'(ee));
    check({tag, " ovf8"}, int'(OVF8), int'(eo));
    BTN = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!VALID || DOUT != ed || ERR != ee || OVF8 != eo) bad++;
    end
    check({tag, " hold_stable"}, bad, 0);
  endtask

  task automatic do_ack(input string tag);
    logic [15:0] prev;
    prev = DOUT;
    ACK = 1'b1;
    @(negedge clk);
    ACK = 1'b0;
    check({tag, " valid_after_ack"}, int'(VALID), 0);
    check({tag, " dout_kept"}, int'(DOUT), int'(prev));
    @(negedge clk);
    check({tag, " idle_after_ack"}, int'(BUSY), 0);
  endtask

  task automatic watch_idle(input int cycles, input string tag);
    int busy_seen;
    busy_seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (BUSY) busy_seen++;
    end
    check({tag, " no_conversion"}, busy_seen, 0);
  endtask

  vec_t vecs[8];
  int   bounce[10] = '{3, 1, 2, 3, 1, 1, 3, 2, 3, 3};

  initial begin
    logic [15:0] ed;
    logic        ee;
    logic        eo;
    logic [15:0] r;
    int          c, valid_c, bad;

    RESET = 1'b1; SW = 16'h0000; BTN = 1'b0; ACK = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({DOUT, VALID, ERR, OVF8, BUSY}), 0);
    RESET = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_reset", int'({VALID, BUSY}), 0);

    vecs[0] = '{16'h0255, 16'h0255};
    vecs[1] = '{16'h9999, 16'h9999};
    vecs[2] = '{16'h0000, 16'h0000};
    vecs[3] = '{16'h12A4, 16'h12A4};
    vecs[4] = '{16'h0256, 16'h0256};
    vecs[5] = '{16'h0100, 16'h0100};
    vecs[6] = '{16'hF000, 16'hF000};
    vecs[7] = '{16'h1234, 16'h9876};   // switches move during CONV
    for (int i = 0; i < 8; i++) begin
      do_conv(vecs[i].sw, vecs[i].sw_mid, $sformatf("vec%0d_%04h", i, vecs[i].sw));
      do_ack($sformatf("vec%0d", i));
    end

    // Bounce: pulses of at most 3 clocks must never produce a load.
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      BTN = (i % 2 == 0);
      repeat (bounce[i]) begin
        @(negedge clk);
        if (BUSY) bad++;
      end
    end
    BTN = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (BUSY) bad++;
    end
    check("bounce_busy_cycles", bad, 0);
    do_conv(16'h0042, 16'h0042, "after_bounce");
    do_ack("after_bounce");
    watch_idle(20, "after_bounce_single");

    // Second press while HOLD is dropped.
    do_conv(16'h0777, 16'h0777, "hold_press");
    model(16'h0777, ed, ee, eo);
    BTN = 1'b1;
    bad = 0;
    repeat (12) begin @(negedge clk); if (!VALID || DOUT != ed) bad++; end
    BTN = 1'b0;
    repeat (10) begin @(negedge clk); if (!VALID || DOUT != ed) bad++; end
    check("hold_press_ignored", bad, 0);
    do_ack("hold_press");
    watch_idle(20, "hold_press_after_ack");

    // ACK and load arrive on the same HOLD edge: ACK wins, load is lost.
    do_conv(16'h0031, 16'h0031, "ack_load");
    BTN = 1'b1;
    repeat (6) @(negedge clk);
    ACK = 1'b1;
    @(negedge clk);
    ACK = 1'b0;
    check("ack_load valid", int'(VALID), 0);
    check("ack_load busy", int'(BUSY), 0);
    repeat (10) @(negedge clk);
    BTN = 1'b0;
    watch_idle(20, "ack_load");

    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 3) == 0) r = 16'($urandom);
      else r = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      do_conv(r, 16'($urandom), $sformatf("rand%0d_%04h", k, r));
      do_ack($sformatf("rand%0d", k));
    end

    // Reset mid-conversion with the button held through release.
    SW = 16'h0512;
    repeat (3) @(negedge clk);
    BTN = 1'b1;
    c = 0;
    while (!BUSY && c < 50) begin @(negedge clk); c++; end
    check("rst_mid busy_seen", int'(BUSY), 1);
    repeat (7) @(negedge clk);
    RESET = 1'b1;
    #1;
    check("rst_mid outputs", int'({DOUT, VALID, ERR, OVF8, BUSY}), 0);
    repeat (3) @(negedge clk);
    RESET = 1'b0;
    c = 0; valid_c = -1;
    while (valid_c < 0 && c < 100) begin
      @(negedge clk);
      c++;
      if (VALID) valid_c = c;
    end
    model(16'h0512, ed, ee, eo);
    check("rst_release latency", valid_c, 21);
    check("rst_release dout", int'(DOUT), int'(ed));
    check("rst_release ovf8", int'(OVF8), int'(eo));
    BTN = 1'b0;
    repeat (10) @(negedge clk);
    do_ack("rst_release");
    watch_idle(20, "rst_release_single");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
